uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single Uart8 transmitter between NUM_REQ byte sources using round-robin arbitration.
//  Each requester can lock the transmitter for a multi-byte packet.
//  Sequences the Uart8 tx interface (txEn/txStart/txIn, txBusy/txDone) and supervises it with a start timeout.
//  Sits between the application byte producers and the Uart8 instance.
// PARAMETERS
//  NUM_REQ         4   number of requesters, >=1
//  TIMEOUT_CYCLES  16  max clk cycles from txStart to txBusy high before the byte is abandoned
//  IDLE_GAP        0   idle clk cycles inserted after each txDone before the next txStart
// PORTS
//  clk        in   1            system clock, all state on rising edge
//  rstN       in   1            asynchronous, active-low reset
//  reqValid   in   NUM_REQ      requester i has a byte on reqData[8i+7:8i]
//  reqData    in   8*NUM_REQ    flat byte bus, slot i = [8i+7:8i]
//  reqLast    in   NUM_REQ      byte is last of packet; 0 keeps the lock on requester i
//  reqReady   out  NUM_REQ      one-hot accept; transfer = reqValid[i] & reqReady[i]
//  grantId    out  GW           GW = max(1,$clog2(NUM_REQ)); owner of current/last byte
//  txEn       out  1            Uart8 tx enable
//  txStart    out  1            one-cycle start strobe to Uart8
//  txData     out  8            byte to Uart8 txIn, stable from txStart until txDone
//  txBusy     in   1            Uart8 transmitting
//  txDone     in   1            Uart8 frame complete pulse
//  sentPulse  out  1            one cycle per byte completed
//  errTimeout out  1            one cycle when TIMEOUT_CYCLES expires
// BEHAVIOUR
//  Reset values: reqReady=0, txEn=0, txStart=0, txData=0, grantId=0, sentPulse=0, errTimeout=0, lock=0.
//  Reset also sets: rrPtr=NUM_REQ-1, so requester 0 wins first; state=DRAIN.
//  txEn goes 1 on the first clk after reset release and stays 1.
//  FSM states: DRAIN, IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
//  DRAIN:
//   - Waits for txBusy=0, because Uart8 may still be sending after a mid-frame reset.
//   - Then goes to IDLE. No txStart is issued while in DRAIN.
//  IDLE, lock=0:
//   - winner = first i with reqValid[i], searching from (rrPtr+1) mod NUM_REQ upward with wrap.
//   - reqReady[winner]=1 combinationally in the same cycle.
//   - On transfer: txData<=byte, grantId<=winner, rrPtr<=winner, lock<=~reqLast[winner]; go to START.
//  IDLE, lock=1:
//   - Only reqReady[grantId] may assert; other requesters wait indefinitely.
//   - The lock is released only by a reqLast=1 byte, a timeout, or reset.
//  START: txStart=1 for exactly one cycle; timer<=0; go to WAIT_BUSY.
//   - Latency: reqValid sampled in IDLE -> txStart on the next cycle.
//  WAIT_BUSY:
//   - txDone=1 (takes precedence, short frame or missed busy): treat as completion.
//   - Else txBusy=1: go to WAIT_DONE.
//   - Else timer++. When timer==TIMEOUT_CYCLES-1: errTimeout=1, lock<=0, byte dropped, go to IDLE.
//  WAIT_DONE: on txDone, sentPulse=1; go to GAP if IDLE_GAP>0, else IDLE.
//  GAP: counts IDLE_GAP cycles, then goes to IDLE.
//  Back-to-back bytes:
//   - txDone in cycle n -> reqReady in cycle n+1+IDLE_GAP -> txStart in cycle n+2+IDLE_GAP.
//  Timer width: $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
//  reqValid dropping while not accepted is legal; no byte is taken.
//  reqData is only sampled in the transfer cycle.
//  NUM_REQ=1: arbitration degenerates and grantId is constant 0.
// STRUCTURE
//  Shared package uart_pkg:
//   - localparam FSM state encodings: DRAIN, IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
//   - localparam UART_DATA_W = 8.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs one-hot gnt[N] and index.
//   - Purely combinational.
//   - Instantiated once; the FSM, timer, gap counter and lock stay in uart_tx_arbiter.
// TESTING
//  1 Single byte: req0 sends 0x35, last=1.
//    -> reqReady[0] high for 1 cycle; next cycle txStart with txData=0x35.
//    -> Model Uart8 busy/done; one sentPulse; grantId=0.
//  2 Fairness: reqValid=4'b0111 held, all last=1, distinct bytes.
//    -> txStart order 0,1,2,0,1,2; requester 3 is never granted.
//  3 Lock: req1 sends 0xA1 (last=0) then 0xA2 (last=1) while req0 is valid throughout.
//    -> 0xA1,0xA2 sent consecutively, then req0's byte.
//  4 Timeout: txBusy tied 0.
//    -> errTimeout exactly TIMEOUT_CYCLES cycles after txStart; lock cleared.
//    -> Next pending requester granted; no sentPulse.
//  5 Reset mid-frame: assert rstN=0 during WAIT_DONE with txBusy=1.
//    -> All outputs take reset values immediately; no txStart until txBusy=0.
//  6 txDone in WAIT_BUSY with txBusy never high.
//    -> sentPulse=1, no errTimeout; IDLE_GAP=3 gives 3 idle cycles before the next reqReady.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the Uart8 transmit arbiter: byte width, FSM states
// and an index-width helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        DRAIN     = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } tx_state_t;

    // Index width that never collapses to zero bits for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: the first requester strictly after ptr
// (with wrap) wins; ptr itself is searched last.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic         found;
    logic [W-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = W'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter among NUM_REQ byte sources with round-robin
// arbitration, per-requester packet locking and a txStart-to-txBusy timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 16,
    parameter int  IDLE_GAP       = 0,
    localparam int GW             = idx_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]             reqLast,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic [GW-1:0]                  grantId,
    output logic                           txEn,
    output logic                           txStart,
    output logic [UART_DATA_W-1:0]         txData,
    input  logic                           txBusy,
    input  logic                           txDone,
    output logic                           sentPulse,
    output logic                           errTimeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] GAP_LAST   = CW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam bit            HAS_GAP    = (IDLE_GAP > 0);

    tx_state_t                state;
    logic [GW-1:0]            rr_ptr;
    logic                     lock;
    logic [TW-1:0]            timer;
    logic [CW-1:0]            gap_cnt;
    logic [NUM_REQ-1:0]       arb_gnt;
    logic [GW-1:0]            arb_idx;
    logic [GW-1:0]            sel_idx;
    logic [UART_DATA_W-1:0]   sel_byte;
    logic                     accept;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (GW)
    ) u_rr (
        .req (reqValid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // While a packet holds the lock only its owner may be accepted
    always_comb begin
        reqReady = '0;
        if (state == IDLE) begin
            if (lock) begin
                reqReady[grantId] = reqValid[grantId];
            end else begin
                reqReady = arb_gnt;
            end
        end
    end

    assign sel_idx = lock ? grantId : arb_idx;
    assign accept  = |(reqValid & reqReady);

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == sel_idx) begin
                sel_byte = reqData[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    // Reported in the cycle the last allowed wait elapses, so it lands
    // exactly TIMEOUT_CYCLES after the txStart strobe
    assign errTimeout = (state == WAIT_BUSY) && !txDone && !txBusy && (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= DRAIN;
            rr_ptr    <= GW'(NUM_REQ - 1);
            lock      <= 1'b0;
            timer     <= '0;
            gap_cnt   <= '0;
            grantId   <= '0;
            txEn      <= 1'b0;
            txStart   <= 1'b0;
            txData    <= '0;
            sentPulse <= 1'b0;
        end else begin
            txEn      <= 1'b1;
            txStart   <= 1'b0;
            sentPulse <= 1'b0;
            case (state)
                DRAIN: begin
                    if (!txBusy) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        txData  <= sel_byte;
                        grantId <= sel_idx;
                        rr_ptr  <= sel_idx;
                        lock    <= ~reqLast[sel_idx];
                        txStart <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                // A done pulse counts as completion even if busy was never seen
                WAIT_BUSY, WAIT_DONE: begin
                    if (txDone) begin
                        sentPulse <= 1'b1;
                        gap_cnt   <= '0;
                        if (HAS_GAP) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (state == WAIT_BUSY) begin
                        if (txBusy) begin
                            state <= WAIT_DONE;
                        end else if (timer == TIMER_LAST) begin
                            lock  <= 1'b0;
                            state <= IDLE;
                        end else if (timer != TIMER_SAT) begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= DRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level round-robin model
// predicts every txStart; a monitor compares what the DUT actually sends.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TOUT = 16;
    localparam int GAPC = 3;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct {
        logic [7:0] data;
        int         id;
    } exp_t;

    logic              clk;
    logic              rstN;
    logic [NREQ-1:0]   reqValid;
    logic [8*NREQ-1:0] reqData;
    logic [NREQ-1:0]   reqLast;
    logic [NREQ-1:0]   reqReady;
    logic [1:0]        grantId;
    logic              txEn;
    logic              txStart;
    logic [7:0]        txData;
    logic              txBusy;
    logic              txDone;
    logic              sentPulse;
    logic              errTimeout;

    item_t drv_q[NREQ][$];
    item_t mq[NREQ][$];
    exp_t  exp_q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int sent_seen = 0;
    int to_seen = 0;
    int exp_sent = 0;
    int exp_to = 0;
    int uart_mode = 0;
    int uart_m = 0;
    bit hold_busy = 0;
    int m_ptr = NREQ - 1;
    int m_owner = 0;
    bit m_lock = 0;
    logic [NREQ-1:0] drv_hs;
    bit gap_armed = 0;
    int done_cyc = 0;
    int hs_cyc = -10;
    int start_cyc = 0;
    exp_t mon_e;

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TOUT),
        .IDLE_GAP       (GAPC)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .reqValid   (reqValid),
        .reqData    (reqData),
        .reqLast    (reqLast),
        .reqReady   (reqReady),
        .grantId    (grantId),
        .txEn       (txEn),
        .txStart    (txStart),
        .txData     (txData),
        .txBusy     (txBusy),
        .txDone     (txDone),
        .sentPulse  (sentPulse),
        .errTimeout (errTimeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic applyStimulus(input int r, input logic [7:0] d, input logic last);
        item_t it;
        it.data = d;
        it.last = last;
        drv_q[r].push_back(it);
        mq[r].push_back(it);
    endtask

    // mode 0: bytes complete normally, 1: every byte times out, 2: byte lost to reset
    task automatic modelRun(input int mode);
        item_t it;
        exp_t  e;
        int    w;
        forever begin
            w = -1;
            if (m_lock && mq[m_owner].size() > 0) begin
                w = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && mq[(m_ptr + k) % NREQ].size() > 0) w = (m_ptr + k) % NREQ;
                end
            end
            if (w < 0) break;
            it = mq[w].pop_front();
            e.data = it.data;
            e.id = w;
            exp_q.push_back(e);
            m_ptr = w;
            if (mode == 1) begin
                exp_to++;
                m_lock = 1'b0;
            end else begin
                if (mode == 0) exp_sent++;
                m_lock = !it.last;
                m_owner = w;
            end
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("all_expected_bytes_started", exp_q.size(), 0);
        exp_q.delete();
        repeat (TOUT + GAPC + 20) @(posedge clk);
        checkOutput("sentPulse_count", sent_seen, exp_sent);
        checkOutput("errTimeout_count", to_seen, exp_to);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_reqReady"}, int'(reqReady), 0);
        checkOutput({tag, "_txEn"}, int'(txEn), 0);
        checkOutput({tag, "_txStart"}, int'(txStart), 0);
        checkOutput({tag, "_txData"}, int'(txData), 0);
        checkOutput({tag, "_grantId"}, int'(grantId), 0);
        checkOutput({tag, "_sentPulse"}, int'(sentPulse), 0);
        checkOutput({tag, "_errTimeout"}, int'(errTimeout), 0);
    endtask

    // Requester sources: present the head of each queue, retire it after a handshake
    initial begin
        reqValid = '0;
        reqData = '0;
        reqLast = '0;
        forever begin
            @(negedge clk);
            #1;
            drv_hs = reqValid & reqReady;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (drv_hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    reqValid[i] = 1'b1;
                    reqData[8*i +: 8] = drv_q[i][0].data;
                    reqLast[i] = drv_q[i][0].last;
                end else begin
                    reqValid[i] = 1'b0;
                    reqData[8*i +: 8] = 8'h00;
                    reqLast[i] = 1'b0;
                end
            end
        end
    end

    // Uart8 stand-in: 0 normal (sometimes done without busy), 1 silent, 3 busy held
    initial begin
        txBusy = 1'b0;
        txDone = 1'b0;
        forever begin
            @(negedge clk);
            if (txStart) begin
                uart_m = uart_mode;
                if (uart_m == 0) begin
                    @(negedge clk);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if ($urandom_range(0, 2) != 0) begin
                        txBusy = 1'b1;
                        repeat ($urandom_range(1, 5)) @(negedge clk);
                        txBusy = 1'b0;
                    end
                    txDone = 1'b1;
                    @(negedge clk);
                    txDone = 1'b0;
                end else if (uart_m == 3) begin
                    @(negedge clk);
                    txBusy = 1'b1;
                    while (hold_busy) @(negedge clk);
                    txBusy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every txStart and checks timing rules
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rstN) begin
                gap_armed = 1'b0;
            end else begin
                if (reqReady != '0) begin
                    checkOutput("reqReady_onehot_and_valid",
                                int'($onehot(reqReady) && ((reqReady & ~reqValid) == '0)), 1);
                    if (gap_armed) begin
                        checkOutput("done_to_ready_gap", cyc - done_cyc, 1 + GAPC);
                        gap_armed = 1'b0;
                    end
                end
                if ((reqValid & reqReady) != '0) hs_cyc = cyc;
                if (txStart) begin
                    start_cyc = cyc;
                    checkOutput("accept_to_txStart", cyc - hs_cyc, 1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_txStart", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("txData", int'(txData), int'(mon_e.data));
                        checkOutput("grantId", int'(grantId), mon_e.id);
                    end
                end
                if (errTimeout) begin
                    to_seen++;
                    checkOutput("txStart_to_errTimeout", cyc - start_cyc, TOUT);
                end
                if (sentPulse) sent_seen++;
                if (txDone) begin
                    done_cyc = cyc;
                    gap_armed = (reqValid != '0);
                end
            end
        end
    end

    initial begin
        int n;
        int len;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checkResetValues("reset");
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("txEn_after_release", int'(txEn), 1);

        // Single byte from requester 0
        @(negedge clk);
        applyStimulus(0, 8'h35, 1'b1);
        modelRun(0);
        waitDrain();

        // Fairness among three continuously valid requesters
        @(negedge clk);
        for (int rep = 0; rep < 2; rep++) begin
            for (int r = 0; r < 3; r++) applyStimulus(r, 8'(8'h40 + 16 * rep + r), 1'b1);
        end
        modelRun(0);
        waitDrain();

        // Locked two-byte packet from requester 1 while requester 0 waits
        @(negedge clk);
        applyStimulus(1, 8'hA1, 1'b0);
        applyStimulus(1, 8'hA2, 1'b1);
        applyStimulus(0, 8'h0F, 1'b1);
        modelRun(0);
        waitDrain();

        // Random packets on all requesters
        for (int round = 0; round < 3; round++) begin
            @(negedge clk);
            for (int r = 0; r < NREQ; r++) begin
                for (int p = 0; p < 2; p++) begin
                    if ($urandom_range(0, 3) != 0) begin
                        len = $urandom_range(1, 3);
                        for (int b = 0; b < len; b++) applyStimulus(r, 8'($urandom), b == len - 1);
                    end
                end
            end
            modelRun(0);
            waitDrain();
        end

        // Transmitter never responds: each byte must time out and drop its lock
        @(negedge clk);
        uart_mode = 1;
        applyStimulus(2, 8'hC1, 1'b0);
        applyStimulus(2, 8'hC2, 1'b1);
        applyStimulus(3, 8'hD3, 1'b1);
        modelRun(1);
        waitDrain();
        uart_mode = 0;

        // Reset while a frame is on the wire
        @(negedge clk);
        uart_mode = 3;
        hold_busy = 1'b1;
        applyStimulus(2, 8'h5A, 1'b1);
        modelRun(2);
        n = 0;
        while (!txBusy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_before_reset", int'(txBusy), 1);
        repeat (2) @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkResetValues("midframe_reset");
        m_ptr = NREQ - 1;
        m_lock = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rstN = 1'b1;
        @(negedge clk);
        uart_mode = 0;
        applyStimulus(3, 8'h33, 1'b1);
        applyStimulus(1, 8'h11, 1'b1);
        modelRun(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            checkOutput("drain_no_txStart", int'(txStart), 0);
            checkOutput("drain_no_reqReady", int'(reqReady), 0);
            checkOutput("drain_txEn", int'(txEn), 1);
        end
        hold_busy = 1'b0;
        waitDrain();

        // One more random round after the reset
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) applyStimulus(r, 8'($urandom), b == len - 1);
        end
        modelRun(0);
        waitDrain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
